uartrx_controller: RTL
======================

Name: uartrx_controller

Overview:
Receive control unit for the UART RX path. It synchronises the serial line, detects and validates the start bit, and sequences the bit timer (enable/clear, packet_done) and the 9-bit receive shift register (8 data bits plus stop bit). It checks the stop bit, loads the data buffer, and maintains the data_ready, overrun and framing status toward the host side.

Parameters:
DATA_BITS, 8, width of the received data word and of the packet_data input.
CLKS_PER_BIT, 10, clocks per serial bit; must match the timer rollover value. HALF_BIT = CLKS_PER_BIT/2 (integer division).
SYNC_STAGES, 2, flops in the serial_in synchroniser (minimum 2).

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  synchronous, active-high reset
serial_in  input  1  raw asynchronous serial line; idle level 1
packet_done  input  1  from bit timer; high for one cycle after the stop-bit sample strobe
stop_bit  input  1  stop-bit position of the shift register
packet_data  input  DATA_BITS  data positions of the shift register
data_read  input  1  host acknowledges rx_data
enable_timer  output  1  count enable to the bit timer
timer_clear  output  1  one-cycle clear pulse to both timer counters
rx_data  output  DATA_BITS  received data buffer
data_ready  output  1  rx_data holds an unread word
overrun_error  output  1  a word was loaded while data_ready was already 1
framing_error  output  1  the last packet had stop_bit = 0

Behaviour:
- Reset (rst = 1 at an edge):
  - State goes to IDLE; all synchroniser flops and the previous-sample flop go to 1.
  - rx_data = 0; data_ready, overrun_error, framing_error, enable_timer, timer_clear = 0.
- Synchroniser: `sync` is the last stage of a SYNC_STAGES shift chain. `prev` holds sync delayed by one cycle. A start edge is prev = 1 and sync = 0.
- IDLE:
  - enable_timer = 0.
  - On a start edge: go to START_CHK, clear the half-bit counter hcnt, clear framing_error.
- START_CHK:
  - hcnt increments each cycle.
  - When hcnt == HALF_BIT-1:
    - If sync = 0, the start bit is valid: assert timer_clear for that cycle and go to RECEIVE.
    - If sync = 1, it was a glitch: return to IDLE with no flag change.
- RECEIVE:
  - enable_timer = 1, so timer strobes fall mid-bit.
  - On packet_done = 1: go to STOP_CHK; enable_timer drops in STOP_CHK.
- STOP_CHK (one cycle):
  - If stop_bit = 1:
    - rx_data <= packet_data and data_ready <= 1, both visible 2 cycles after the packet_done cycle.
    - overrun_error <= 1 if data_ready = 1 and data_read = 0 in this cycle.
    - Go to IDLE.
  - If stop_bit = 0: framing_error <= 1, rx_data is unchanged, go to BREAK_WAIT.
- BREAK_WAIT:
  - enable_timer = 0.
  - Stay until sync = 1, then go to IDLE. A held-low line (break) never starts a new packet.
- data_read:
  - When data_ready = 1, it clears data_ready and overrun_error on the next edge.
  - If data_read coincides with a STOP_CHK load, the load wins: data_ready stays 1 and no overrun is flagged.
  - data_read while data_ready = 0 has no effect.
- framing_error stays set until the next validated start edge (entry to START_CHK) or reset.
- Reset asserted mid-packet:
  - Returns to IDLE on that edge with enable_timer = 0.
  - The first START_CHK→RECEIVE transition pulses timer_clear, so stale timer counts are discarded.
- Illegal state encodings return to IDLE.
- Outputs are all registered or state-decoded; there are no combinational paths from serial_in.

Decomposition:
- A shared package uartrx_pkg holds:
  - the state enum (IDLE, START_CHK, RECEIVE, STOP_CHK, BREAK_WAIT);
  - the CLKS_PER_BIT and DATA_BITS defaults;
  - the HALF_BIT derivation.
- One sub-module is natural: uartrx_sync_edge, holding the SYNC_STAGES synchroniser plus the start-edge detector. Its outputs are sync and start_edge, and it resets to 1.

Test Plan:
1. Frame 0xA5 (LSB first, stop = 1) at 10 clk/bit. The bench drives packet_done/packet_data as the timer would → data_ready rises 2 cycles after packet_done, rx_data = 0xA5, and both error flags stay 0.
2. Low glitch of 3 cycles on serial_in while idle → state returns to IDLE, enable_timer is never asserted, and no timer_clear pulse occurs.
3. Frame 0x3C with stop_bit = 0, line then held low for 40 cycles → framing_error = 1 and rx_data is unchanged. No new packet starts until the line goes high; the next valid start clears framing_error.
4. Two frames 0x11 then 0x22 with no data_read in between → rx_data = 0x22 and overrun_error = 1. A data_read pulse then clears data_ready and overrun_error on the next edge.
5. data_read asserted in the STOP_CHK cycle of frame 0x7E while data_ready = 1 → data_ready stays 1, rx_data = 0x7E, overrun_error = 0.
6. rst asserted mid-RECEIVE → the next edge shows all outputs 0 and state IDLE. The next frame 0x55 is received correctly, with timer_clear pulsed once.

Source files
------------

// File: rtl/uartrx_pkg.sv
// Shared definitions for the UART receive controller: state encoding,
// default sizing and the half-bit timing derivation.
package uartrx_pkg;

    localparam int DATA_BITS_DEF    = 8;
    localparam int CLKS_PER_BIT_DEF = 10;
    localparam int SYNC_STAGES_DEF  = 2;

    // Receive sequencer states.
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_START_CHK  = 3'd1,
        S_RECEIVE    = 3'd2,
        S_STOP_CHK   = 3'd3,
        S_BREAK_WAIT = 3'd4
    } uartrx_state_e;

    // Plain vector constants of the same encoding, so the FSM register can
    // stay a raw logic vector and still decode illegal codes explicitly.
    localparam logic [2:0] IDLE       = S_IDLE;
    localparam logic [2:0] START_CHK  = S_START_CHK;
    localparam logic [2:0] RECEIVE    = S_RECEIVE;
    localparam logic [2:0] STOP_CHK   = S_STOP_CHK;
    localparam logic [2:0] BREAK_WAIT = S_BREAK_WAIT;

    // Start bit is re-sampled this many clocks after the falling edge.
    function automatic int half_bit(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/uartrx_sync_edge.sv
// Serial line synchroniser and start-edge detector. All flops reset to the
// idle line level (1) so no false start edge appears after reset.
module uartrx_sync_edge
    import uartrx_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic serial_in,
    output logic sync,
    output logic start_edge
);

    logic [SYNC_STAGES-1:0] chain_reg;
    logic                   prev_reg;

    // Shift the raw line through the synchroniser and keep one delayed copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_reg <= '1;
            prev_reg  <= 1'b1;
        end else begin
            chain_reg <= {chain_reg[SYNC_STAGES-2:0], serial_in};
            prev_reg  <= chain_reg[SYNC_STAGES-1];
        end
    end

    assign sync       = chain_reg[SYNC_STAGES-1];
    assign start_edge = prev_reg & ~sync;

endmodule

// File: rtl/uartrx_controller.sv
// UART receive control unit: validates the start bit, sequences the external
// bit timer and shift register, checks the stop bit and keeps host status.
module uartrx_controller
    import uartrx_pkg::*;
#(
    parameter int DATA_BITS    = DATA_BITS_DEF,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int SYNC_STAGES  = SYNC_STAGES_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    input  logic                 packet_done,
    input  logic                 stop_bit,
    input  logic [DATA_BITS-1:0] packet_data,
    input  logic                 data_read,
    output logic                 enable_timer,
    output logic                 timer_clear,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 overrun_error,
    output logic                 framing_error
);

    localparam int HALF_BIT = half_bit(CLKS_PER_BIT);
    localparam int HCNT_W   = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;
    localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(HALF_BIT - 1);

    logic                 sync;
    logic                 start_edge;
    logic [2:0]           state_reg, state_next;
    logic [HCNT_W-1:0]    hcnt_reg, hcnt_next;
    logic                 half_done;
    logic                 load_word;
    logic                 frame_bad;
    logic                 host_ack;
    logic                 start_accept;
    logic [DATA_BITS-1:0] rx_data_reg;
    logic                 data_ready_reg;
    logic                 overrun_reg;
    logic                 framing_reg;

    uartrx_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk       (clk),
        .rst       (rst),
        .serial_in (serial_in),
        .sync      (sync),
        .start_edge(start_edge)
    );

    assign half_done    = (hcnt_reg == HCNT_LAST);
    assign start_accept = (state_reg == IDLE) && start_edge;
    assign load_word    = (state_reg == STOP_CHK) && stop_bit;
    assign frame_bad    = (state_reg == STOP_CHK) && !stop_bit;
    assign host_ack     = data_read && data_ready_reg;

    // Next-state and half-bit counter logic; unknown codes fall back to IDLE.
    always_comb begin
        state_next = state_reg;
        hcnt_next  = hcnt_reg;
        case (state_reg)
            IDLE: begin
                if (start_edge) begin
                    state_next = START_CHK;
                    hcnt_next  = '0;
                end
            end
            START_CHK: begin
                hcnt_next = hcnt_reg + HCNT_W'(1);
                if (half_done) begin
                    state_next = sync ? IDLE : RECEIVE;
                end
            end
            RECEIVE: begin
                if (packet_done) begin
                    state_next = STOP_CHK;
                end
            end
            STOP_CHK: begin
                state_next = stop_bit ? IDLE : BREAK_WAIT;
            end
            BREAK_WAIT: begin
                // A held-low line must return high before a new start counts.
                if (sync) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and half-bit counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            hcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            hcnt_reg  <= hcnt_next;
        end
    end

    // Host-side status: a load always wins over a coincident acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_reg    <= '0;
            data_ready_reg <= 1'b0;
            overrun_reg    <= 1'b0;
            framing_reg    <= 1'b0;
        end else begin
            if (load_word) begin
                rx_data_reg <= packet_data;
            end
            data_ready_reg <= load_word | (data_ready_reg & ~data_read);
            overrun_reg    <= (load_word & data_ready_reg & ~data_read)
                            | (overrun_reg & ~host_ack);
            if (start_accept) begin
                framing_reg <= 1'b0;
            end else if (frame_bad) begin
                framing_reg <= 1'b1;
            end
        end
    end

    // Timer controls decode only registered state, never the raw line.
    assign enable_timer  = (state_reg == RECEIVE);
    assign timer_clear   = (state_reg == START_CHK) && half_done && !sync;

    assign rx_data       = rx_data_reg;
    assign data_ready    = data_ready_reg;
    assign overrun_error = overrun_reg;
    assign framing_error = framing_reg;

endmodule
